// File: rtl/csa_ctrl_pkg.sv
// Shared types and constants for the checked-adder sequencer.
package csa_ctrl_pkg;

  localparam int unsigned DATA_W = 64;

  // Completion code; 2'b11 is reserved.
  typedef enum logic [1:0] {
    STAT_OK     = 2'b00,
    STAT_PARITY = 2'b01,
    STAT_DUP    = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StExec  = 2'b01,
    StCheck = 2'b10,
    StDone  = 2'b11
  } state_e;

  // Even parity of a data word.
  function automatic logic parity64(input logic [DATA_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/csa_check_sequencer_if.sv
// Request/response bundle of the checked-adder sequencer.
interface csa_check_sequencer_if
  import csa_ctrl_pkg::*;
#(
  parameter int unsigned ERRCNT_W = 16
) ();

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_a;
  logic [DATA_W-1:0]   in_b;
  logic                in_pa;
  logic                in_pb;
  logic [DATA_W-1:0]   fi_mask;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_sum;
  logic                out_par;
  status_e             out_status;
  logic [2:0]          out_retries;
  logic [ERRCNT_W-1:0] err_count;

  // Requester / consumer side.
  modport master (
    output in_valid, in_a, in_b, in_pa, in_pb, fi_mask, out_ready,
    input  in_ready, out_valid, out_sum, out_par, out_status, out_retries, err_count
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, in_pa, in_pb, fi_mask, out_ready,
    output in_ready, out_valid, out_sum, out_par, out_status, out_retries, err_count
  );

endinterface

// File: rtl/duplicated_carry_select_adder_64b.sv
// 64-bit carry-select adder with a duplicated, inverted sum rail and parity prediction.
module duplicated_carry_select_adder_64b
  import csa_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              pa,
  input  logic              pb,
  output logic [DATA_W-1:0] s,
  output logic [DATA_W-1:0] s_invert,
  output logic              papb,
  output logic              pab
);

  localparam int unsigned BlkW   = 16;
  localparam int unsigned NumBlk = DATA_W / BlkW;

  // Carry into each block, one chain per rail.
  logic [NumBlk-1:0] w_c;
  logic [NumBlk-1:0] w_rc;
  logic [DATA_W-1:0] w_rsum;

  assign w_c[0]  = 1'b0;
  assign w_rc[0] = 1'b0;

  for (genvar i = 0; i < NumBlk; i++) begin : g_blk
    // The top block drops its carry-out (mod 2^64 add), so it carries no extra bit.
    localparam int unsigned Ext  = (i < NumBlk - 1) ? 1 : 0;
    localparam int unsigned SumW = BlkW + Ext;

    logic [SumW-1:0] w_s0, w_s1, w_r0, w_r1;

    assign w_s0 = SumW'(a[i*BlkW +: BlkW]) + SumW'(b[i*BlkW +: BlkW]);
    assign w_s1 = SumW'(a[i*BlkW +: BlkW]) + SumW'(b[i*BlkW +: BlkW]) + SumW'(1);
    assign w_r0 = SumW'(a[i*BlkW +: BlkW]) + SumW'(b[i*BlkW +: BlkW]);
    assign w_r1 = SumW'(a[i*BlkW +: BlkW]) + SumW'(b[i*BlkW +: BlkW]) + SumW'(1);

    assign s[i*BlkW +: BlkW]      = w_c[i]  ? w_s1[BlkW-1:0] : w_s0[BlkW-1:0];
    assign w_rsum[i*BlkW +: BlkW] = w_rc[i] ? w_r1[BlkW-1:0] : w_r0[BlkW-1:0];

    if (i < NumBlk - 1) begin : g_cy
      assign w_c[i+1]  = w_c[i]  ? w_s1[BlkW] : w_s0[BlkW];
      assign w_rc[i+1] = w_rc[i] ? w_r1[BlkW] : w_r0[BlkW];
    end
  end

  assign s_invert = ~w_rsum;
  assign papb     = pa ^ pb;
  assign pab      = (^a) ^ (^b);

endmodule

// File: rtl/csa_check_sequencer.sv
// Sequencer: captures operands, runs the duplicated adder, checks parity and rails, retries.
module csa_check_sequencer
  import csa_ctrl_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned ERRCNT_W  = 16
) (
  input logic                  clk,
  input logic                  reset,
  csa_check_sequencer_if.slave bus
);

  localparam logic [2:0] MaxRetry = 3'(MAX_RETRY);

  state_e              r_state;
  logic [DATA_W-1:0]   r_a, r_b;
  logic                r_pa, r_pb;
  logic [2:0]          r_retry;
  logic [DATA_W-1:0]   r_s, r_sinv;
  logic                r_papb, r_pab;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_sum;
  logic                r_out_par;
  status_e             r_out_status;
  logic [2:0]          r_out_retries;
  logic [ERRCNT_W-1:0] r_err_count;

  logic [DATA_W-1:0]   w_s, w_sinv;
  logic                w_papb, w_pab;
  logic                w_par_err, w_dup_err;
  status_e             w_status;

  duplicated_carry_select_adder_64b u_adder (
    .a        (r_a),
    .b        (r_b),
    .pa       (r_pa),
    .pb       (r_pb),
    .s        (w_s),
    .s_invert (w_sinv),
    .papb     (w_papb),
    .pab      (w_pab)
  );

  assign w_par_err = (r_papb != r_pab);
  assign w_dup_err = (r_s != ~r_sinv);

  // Completion code of a CHECK that finishes; parity outranks a rail mismatch.
  always_comb begin
    w_status = STAT_OK;
    if (w_par_err) begin
      w_status = STAT_PARITY;
    end else if (w_dup_err) begin
      w_status = STAT_DUP;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= StIdle;
      r_a           <= '0;
      r_b           <= '0;
      r_pa          <= 1'b0;
      r_pb          <= 1'b0;
      r_retry       <= '0;
      r_s           <= '0;
      r_sinv        <= '0;
      r_papb        <= 1'b0;
      r_pab         <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_sum     <= '0;
      r_out_par     <= 1'b0;
      r_out_status  <= STAT_OK;
      r_out_retries <= '0;
      r_err_count   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_a     <= bus.in_a;
            r_b     <= bus.in_b;
            r_pa    <= bus.in_pa;
            r_pb    <= bus.in_pb;
            r_retry <= '0;
            r_state <= StExec;
          end
        end
        StExec: begin
          r_s     <= w_s ^ bus.fi_mask;
          r_sinv  <= w_sinv;
          r_papb  <= w_papb;
          r_pab   <= w_pab;
          r_state <= StCheck;
        end
        StCheck: begin
          if (!w_par_err && w_dup_err && (r_retry < MaxRetry)) begin
            // Re-run on the held operands; fi_mask is sampled afresh.
            r_retry <= r_retry + 3'd1;
            r_state <= StExec;
          end else begin
            r_out_valid   <= 1'b1;
            r_out_sum     <= r_s;
            r_out_par     <= parity64(r_s);
            r_out_status  <= w_status;
            r_out_retries <= r_retry;
            if ((w_status != STAT_OK) && (r_err_count != {ERRCNT_W{1'b1}})) begin
              r_err_count <= r_err_count + ERRCNT_W'(1);
            end
            r_state <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Ready only in IDLE and never while reset is held.
  assign bus.in_ready    = (r_state == StIdle) && !reset;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_sum     = r_out_sum;
  assign bus.out_par     = r_out_par;
  assign bus.out_status  = r_out_status;
  assign bus.out_retries = r_out_retries;
  assign bus.err_count   = r_err_count;

endmodule

// File: tb/tb_csa_check_sequencer.sv
// Directed bench for csa_check_sequencer (small error counter so saturation is reachable).
module tb_csa_check_sequencer;
  import csa_ctrl_pkg::*;

  localparam int unsigned EW = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  csa_check_sequencer_if #(.ERRCNT_W(EW)) bus ();

  csa_check_sequencer #(
    .MAX_RETRY (2),
    .ERRCNT_W  (EW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request; lat counts edges from the accept edge to the first out_valid.
  task automatic run_txn(input logic [63:0] a, input logic [63:0] b, input logic pa,
                         input logic pb, input logic [63:0] m_first, input logic [63:0] m_rest,
                         output int lat);
    int guard = 0;
    while (!bus.in_ready && guard < 20) begin
      tick();
      guard++;
    end
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_pa    = pa;
    bus.in_pb    = pb;
    bus.fi_mask  = m_first;
    bus.in_valid = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) bus.in_valid = 1'b0;
      if (lat == 2) bus.fi_mask = m_rest;
    end while (!bus.out_valid && lat < 30);
    bus.fi_mask = '0;
  endtask

  task automatic chk_result(input string tag, input logic [63:0] sum, input logic par,
                            input status_e st, input logic [2:0] rt, input int lat_obs,
                            input int lat_exp, input logic [EW-1:0] err);
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, ".sum"}, bus.out_sum, sum);
    chk({tag, ".par"}, 64'(bus.out_par), 64'(par));
    chk({tag, ".status"}, 64'(bus.out_status), 64'(st));
    chk({tag, ".retries"}, 64'(bus.out_retries), 64'(rt));
    chk({tag, ".latency"}, 64'(lat_obs), 64'(lat_exp));
    chk({tag, ".err"}, 64'(bus.err_count), 64'(err));
  endtask

  initial begin
    int lat;
    int acc[$];
    int nres;
    logic rdy;
    logic [EW-1:0] exp_err;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_pa     = 1'b0;
    bus.in_pb     = 1'b0;
    bus.fi_mask   = '0;
    bus.out_ready = 1'b1;
    reset         = 1'b0;
    #1 reset = 1'b1;
    #12;
    chk("rst.in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst.valid", 64'(bus.out_valid), 64'd0);
    chk("rst.sum", bus.out_sum, 64'd0);
    chk("rst.status", 64'(bus.out_status), 64'(STAT_OK));
    chk("rst.err", 64'(bus.err_count), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle.in_ready", 64'(bus.in_ready), 64'd1);

    // Fault-free add with a carry across bit 32.
    run_txn(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1, '0, '0, lat);
    chk_result("t1", 64'h0000_0001_0000_0000, 1'b1, STAT_OK, 3'd0, lat, 3, 4'd0);

    // Wrap-around, back-to-back with in_valid held.
    while (!bus.in_ready) tick();
    bus.in_a     = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.in_b     = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.in_pa    = 1'b0;
    bus.in_pb    = 1'b0;
    bus.in_valid = 1'b1;
    nres = 0;
    for (int i = 0; i < 12; i++) begin
      rdy = bus.in_ready;
      tick();
      if (rdy && bus.in_valid) begin
        acc.push_back(i);
        if (acc.size() == 2) bus.in_valid = 1'b0;
      end
      if (bus.out_valid) begin
        nres++;
        chk("t2.sum", bus.out_sum, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("t2.status", 64'(bus.out_status), 64'(STAT_OK));
      end
    end
    chk("t2.accepts", 64'(acc.size()), 64'd2);
    chk("t2.results", 64'(nres), 64'd2);
    if (acc.size() == 2) chk("t2.spacing", 64'(acc[1] - acc[0]), 64'd4);

    // Wrong operand parity on a.
    run_txn(64'd3, 64'd5, 1'b1, 1'b0, '0, '0, lat);
    chk_result("t3", 64'd8, 1'b1, STAT_PARITY, 3'd0, lat, 3, 4'd1);

    // Transient rail fault, cleared after the first EXEC.
    run_txn(64'h1234, 64'h1, 1'b1, 1'b1, 64'h1, 64'h0, lat);
    chk_result("t4", 64'h1235, 1'b0, STAT_OK, 3'd1, lat, 5, 4'd1);

    // Parity error and rail mismatch together: parity wins, no retry.
    run_txn(64'd3, 64'd5, 1'b1, 1'b0, 64'h1, 64'h1, lat);
    chk_result("t3b", 64'd9, 1'b0, STAT_PARITY, 3'd0, lat, 3, 4'd2);

    // Persistent fault: retries exhausted, error counter saturates.
    for (int k = 1; k <= 17; k++) begin
      run_txn(64'd1, 64'd2, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, lat);
      exp_err = (2 + k > 15) ? 4'hF : EW'(2 + k);
      if (k == 1) begin
        chk_result("t5", 64'h8000_0000_0000_0003, 1'b1, STAT_DUP, 3'd2, lat, 7, exp_err);
      end else begin
        chk("t5.status", 64'(bus.out_status), 64'(STAT_DUP));
        chk("t5.err", 64'(bus.err_count), 64'(exp_err));
      end
    end

    // Reset while in CHECK aborts silently.
    while (!bus.in_ready) tick();
    bus.in_a     = 64'd7;
    bus.in_b     = 64'd9;
    bus.in_pa    = 1'b1;
    bus.in_pb    = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("t6.valid", 64'(bus.out_valid), 64'd0);
    chk("t6.sum", bus.out_sum, 64'd0);
    chk("t6.retries", 64'(bus.out_retries), 64'd0);
    chk("t6.err", 64'(bus.err_count), 64'd0);
    chk("t6.in_ready", 64'(bus.in_ready), 64'd0);
    #1 reset = 1'b0;
    #1;
    chk("t6.ready_after", 64'(bus.in_ready), 64'd1);
    run_txn(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1, '0, '0, lat);
    chk_result("t6n", 64'h0000_0001_0000_0000, 1'b1, STAT_OK, 3'd0, lat, 3, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
